// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM state encodings and pipeline stage indices shared by the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_STALL = 2'b01, ST_FLUSH = 2'b10} state_t;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: controller<->datapath bus (stall_req/flush_req/flush_pc in, stall/bubble/flush/new_pc out); master=controller, slave=datapath
interface pipe_ctrl_if #(parameter int NUM_STAGES = 6, parameter int PC_W = 32);
  logic [NUM_STAGES-1:0] stall_req;
  logic                  flush_req;
  logic [PC_W-1:0]       flush_pc;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] bubble;
  logic                  flush;
  logic [PC_W-1:0]       new_pc;
  modport master (input stall_req, flush_req, flush_pc, output stall, bubble, flush, new_pc);
  modport slave (output stall_req, flush_req, flush_pc, input stall, bubble, flush, new_pc);
endinterface

// File: rtl/pipe_ctrl_stall_enc.sv
// pipe_ctrl_stall_enc: combinational suffix-OR stall encoder with bubble marker; ports en, stall_req in, stall/bubble out
module pipe_ctrl_stall_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         en,
  input  logic [N-1:0] stall_req,
  output logic [N-1:0] stall,
  output logic [N-1:0] bubble
);
  for (genvar i = 0; i < N; i++) begin : g_stg
    assign stall[i] = en & (|(stall_req >> i));
    if (i == STG_PC) begin : g_pc
      assign bubble[i] = 1'b0;
    end else begin : g_bub
      assign bubble[i] = stall[i-1] & ~stall[i];
    end
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipeline stall/flush controller with watchdog; ports clk, rst, bus (pipe_ctrl_if.master), pipe_state, timeout_err, stall_cycles, flush_count; PIPE_CTRL_PERF_EN enables perf counters
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 6,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      bus,
  output logic [1:0]       pipe_state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int FC_W = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WD_W = MAX_STALL > 0 ? $clog2(MAX_STALL + 1) : 1;
  state_t          state;
  logic [FC_W-1:0] fcnt;
  assign pipe_state = state;
  pipe_ctrl_stall_enc #(.N(NUM_STAGES)) u_enc (
    .en       (state != ST_FLUSH && !bus.flush_req),
    .stall_req(bus.stall_req),
    .stall    (bus.stall),
    .bubble   (bus.bubble)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      bus.flush  <= 1'b0;
      bus.new_pc <= '0;
      fcnt       <= '0;
    end else if (bus.flush_req) begin
      state      <= ST_FLUSH;
      bus.flush  <= 1'b1;
      bus.new_pc <= bus.flush_pc;
      fcnt       <= FC_W'(FLUSH_CYCLES - 1);
    end else if (state == ST_FLUSH) begin
      if (fcnt == '0) begin
        state     <= ST_RUN;
        bus.flush <= 1'b0;
      end else fcnt <= fcnt - 1'b1;
    end else state <= |bus.stall_req ? ST_STALL : ST_RUN;
  end
  if (MAX_STALL > 0) begin : g_wd
    logic [WD_W-1:0] wd;
    always_ff @(posedge clk) begin
      if (rst) begin
        wd          <= '0;
        timeout_err <= 1'b0;
      end else begin
        wd <= (bus.flush_req || state == ST_FLUSH || !(|bus.stall_req)) ? '0 :
              wd == WD_W'(MAX_STALL) ? wd : wd + 1'b1;
        if (wd == WD_W'(MAX_STALL)) timeout_err <= 1'b1;
      end
    end
  end else begin : g_no_wd
    assign timeout_err = 1'b0;
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (|bus.stall) stall_cycles <= stall_cycles + 1'b1;
      if (bus.flush_req) flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed-vector bench for pipe_ctrl_unit (FLUSH_CYCLES=3, MAX_STALL=4)
module tb_pipe_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pipe_state;
  logic        timeout_err;
  logic [31:0] stall_cycles, flush_count;
  int          n_vec = 0;
  int          n_err = 0;
  pipe_ctrl_if #(.NUM_STAGES(6), .PC_W(32)) bus ();
  pipe_ctrl_unit #(.NUM_STAGES(6), .PC_W(32), .FLUSH_CYCLES(3), .MAX_STALL(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .pipe_state  (pipe_state),
    .timeout_err (timeout_err),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask
  initial begin
    bus.stall_req = '0;
    bus.flush_req = 1'b0;
    bus.flush_pc  = '0;
    do_reset();
    chk("rst_state", pipe_state, 2'b00);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_new_pc", bus.new_pc, 32'h0);
    chk("rst_tmo", timeout_err, 1'b0);
    chk("rst_stall", bus.stall, 6'b0);
    chk("rst_bubble", bus.bubble, 6'b0);
    chk("rst_sc", stall_cycles, 32'h0);
    chk("rst_fc", flush_count, 32'h0);
    bus.stall_req = 6'b000100;
    #1;
    chk("id_stall", bus.stall, 6'b000111);
    chk("id_bubble", bus.bubble, 6'b001000);
    chk("id_state_pre", pipe_state, 2'b00);
    step();
    chk("id_state", pipe_state, 2'b01);
    bus.stall_req = 6'b001000;
    #1;
    chk("ex_stall", bus.stall, 6'b001111);
    chk("ex_bubble", bus.bubble, 6'b010000);
    step();
    chk("ex_state", pipe_state, 2'b01);
    bus.stall_req = 6'b0;
    #1;
    chk("drop_stall", bus.stall, 6'b0);
    chk("drop_bubble", bus.bubble, 6'b0);
    step();
    chk("drop_state", pipe_state, 2'b00);
    bus.stall_req = 6'b100000;
    #1;
    chk("wb_stall", bus.stall, 6'b111111);
    chk("wb_bubble", bus.bubble, 6'b0);
    bus.stall_req = 6'b000001;
    #1;
    chk("pc_stall", bus.stall, 6'b000001);
    chk("pc_bubble", bus.bubble, 6'b000010);
    bus.stall_req = 6'b101001;
    #1;
    chk("multi_stall", bus.stall, 6'b111111);
    chk("multi_bubble", bus.bubble, 6'b0);
    bus.stall_req = 6'b0;
    do_reset();
    bus.stall_req = 6'b001000;
    bus.flush_pc  = 32'h100;
    bus.flush_req = 1'b1;
    #1;
    chk("fl_win_stall", bus.stall, 6'b0);
    chk("fl_win_bubble", bus.bubble, 6'b0);
    step();
    bus.flush_req = 1'b0;
    bus.flush_pc  = 32'hdead;
    #1;
    chk("fl1_flush", bus.flush, 1'b1);
    chk("fl1_pc", bus.new_pc, 32'h100);
    chk("fl1_state", pipe_state, 2'b10);
    chk("fl1_stall", bus.stall, 6'b0);
    step();
    chk("fl2_flush", bus.flush, 1'b1);
    step();
    chk("fl3_flush", bus.flush, 1'b1);
    chk("fl3_pc", bus.new_pc, 32'h100);
    step();
    chk("fl_end_flush", bus.flush, 1'b0);
    chk("fl_end_state", pipe_state, 2'b00);
    chk("fl_end_pc", bus.new_pc, 32'h100);
    chk("fl_end_stall", bus.stall, 6'b001111);
    bus.stall_req = 6'b0;
    do_reset();
    bus.flush_pc  = 32'h100;
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    chk("rs1_flush", bus.flush, 1'b1);
    step();
    chk("rs2_flush", bus.flush, 1'b1);
    bus.flush_pc  = 32'h200;
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    chk("rs3_flush", bus.flush, 1'b1);
    chk("rs3_pc", bus.new_pc, 32'h200);
    step();
    chk("rs4_flush", bus.flush, 1'b1);
    step();
    chk("rs5_flush", bus.flush, 1'b1);
    step();
    chk("rs_end_flush", bus.flush, 1'b0);
    chk("rs_end_state", pipe_state, 2'b00);
    chk("rs_end_pc", bus.new_pc, 32'h200);
    do_reset();
    bus.stall_req = 6'b000010;
    step(3);
    bus.stall_req = 6'b0;
    step(2);
    chk("wd3_tmo", timeout_err, 1'b0);
    bus.stall_req = 6'b000010;
    step(4);
    chk("wd4_pre_tmo", timeout_err, 1'b0);
    bus.stall_req = 6'b0;
    step();
    chk("wd4_tmo", timeout_err, 1'b1);
    step(2);
    chk("wd_sticky", timeout_err, 1'b1);
    bus.stall_req = 6'b000010;
    #1;
    chk("wd_stall_ok", bus.stall, 6'b000011);
    chk("wd_bubble_ok", bus.bubble, 6'b000100);
    bus.stall_req = 6'b0;
    do_reset();
    chk("wd_rst_tmo", timeout_err, 1'b0);
    bus.stall_req = 6'b000100;
    step(5);
    bus.stall_req = 6'b0;
    for (int k = 0; k < 2; k++) begin
      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;
      step(3);
    end
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_sc", stall_cycles, 32'd5);
    chk("perf_fc", flush_count, 32'd2);
`else
    chk("perf_sc_off", stall_cycles, 32'd0);
    chk("perf_fc_off", flush_count, 32'd0);
`endif
    do_reset();
    chk("perf_sc_rst", stall_cycles, 32'd0);
    chk("perf_fc_rst", flush_count, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
